// File: rtl/req_encoder_pkg.sv
// Shared types and helpers for req_encoder: FSM state encoding and index/one-hot conversion.
package req_encoder_pkg;

  localparam int unsigned MAX_N = 16;
  localparam int unsigned MAX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_W-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction

  // Successor of idx modulo n; the round-robin search begins here.
  function automatic logic [MAX_W-1:0] next_index(input logic [MAX_W-1:0] idx,
                                                  input int unsigned n);
    return MAX_W'((32'(idx) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/enc_prio_pick.sv
// Combinational circular priority picker: the first set bit of vec at or after start wins.
module enc_prio_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index
);

  logic [W-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = start + W'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) request encoder with a valid/ready output.
// Define REQ_ENCODER_RR_EN for round-robin selection; the default is lowest-index priority.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         dropped
);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_code_q, out_code_d;
  logic         dropped_q, dropped_d;

  logic         accept;
  logic [N-1:0] code_oh, served, rest, pick_vec;
  logic [W-1:0] pick_start, pick_idx;
  logic         pick_found;

  assign accept   = out_valid_q & out_ready;
  assign code_oh  = N'(onehot(MAX_W'(out_code_q)));
  assign served   = accept ? code_oh : '0;
  assign rest     = pending_q & ~code_oh;
  // While offering, the next pick must skip the code being handed over.
  assign pick_vec = (state_q == OFFER) ? rest : pending_q;

`ifdef REQ_ENCODER_RR_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr_d   = accept ? out_code_q : rr_ptr_q;
  assign pick_start = W'(next_index(MAX_W'(rr_ptr_d), N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= W'(N - 1);
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_start = '0;
`endif

  enc_prio_pick #(.N(N), .W(W)) u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    pending_d   = (pending_q & ~served) | req_in;
    dropped_d   = |(req_in & pending_q & ~served);

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          out_code_d  = pick_idx;
          out_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          if (pick_found) begin
            out_code_d = pick_idx;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      dropped_q   <= dropped_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign pending   = pending_q;
  assign dropped   = dropped_q;

endmodule

// File: doc/req_encoder.md
# req_encoder

Sequential 4-to-2 (parameterisable N-to-log2 N) request encoder, the inverse of the team's one-hot decoder. Latches single-cycle request pulses on N one-hot lines into a pending register and issues each pending index as a binary code over a valid/ready handshake, one code per accepted transfer. It sits in front of any consumer that needs binary indices, such as the decoder itself, a mux select or a register-file address.

## Interface
- N, default 4: number of request lines; power of two, 2..16.
- W, default $clog2(N): code width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N  request pulses; bit i sampled high means index i is requested.
- out_ready  input  1  consumer accepts out_code this cycle.
- out_valid  output  1  out_code holds a valid index.
- out_code  output  W  binary index being offered.
- pending  output  N  registered pending-request vector.
- dropped  output  1  one-cycle pulse: a request hit an already-pending, unserved bit.

## Operation
- States: IDLE and OFFER.
- IDLE:
  - If pending is nonzero, select an index, register it into out_code, set out_valid, and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - out_code and out_valid are held stable until out_ready=1. New requests never change an offered code.
  - On accept (out_valid & out_ready), compute rest = pending & ~onehot(out_code).
  - If rest is nonzero, select the next index from rest and stay in OFFER, giving back-to-back issue.
  - If rest is zero, clear out_valid and go to IDLE.
- Pending update: pending_next = (pending & ~served) | req_in, where served = onehot(out_code) on accept, else 0.
  - A req_in bit equal to the served bit in the same cycle leaves that bit set, so the index is issued again later.
- dropped: asserted for one cycle when (req_in & pending & ~served) is nonzero. pending is unchanged by such a request.
- Default selection is fixed priority: the lowest set index wins.
- Reset values: state=IDLE, pending=0, out_valid=0, out_code=0, dropped=0, RR pointer=N-1.
- Asserting rst mid-offer discards all pending and in-flight codes immediately.

## Timing
- req_in sampled at edge k sets pending after edge k. out_valid rises after edge k+1. Request-to-valid latency is 2 cycles from an idle state.
- Throughput is one code per cycle while out_ready=1 and requests remain pending.
- The accept at edge j clears the served bit after edge j. The next code, if any, is present after edge j.
- All outputs are registered. There is no combinational path from req_in or out_ready to any output.

## Configuration
- REQ_ENCODER_RR_EN defined: round-robin selection.
  - The search starts at (last_issued+1) mod N and wraps at N-1 to 0.
  - last_issued updates on each accept. After reset the pointer is N-1, so the first search starts at index 0.
- REQ_ENCODER_RR_EN undefined: fixed lowest-index priority. The pointer register is not built.

## Structure
- Package req_encoder_pkg holds the state enum typedef (IDLE, OFFER) and the onehot/index helper functions.
- Sub-module enc_prio_pick is purely combinational:
  - Inputs: vector [N-1:0] and start index [W-1:0].
  - Outputs: found and index [W-1:0].
  - Fixed-priority mode ties start to 0.

## Test plan
- Reset mid-offer: with pending=0110 and out_valid=1, pulse rst → out_valid=0, pending=0000, out_code=00 asynchronously; IDLE after release.
- Single request: req_in=0100 for one cycle, out_ready=1 → out_valid high 2 edges later with out_code=10; pending=0000 after accept; out_valid low the next cycle.
- Burst, fixed priority: req_in=1011 for one cycle, out_ready held 1 → out_code 00, 01, 11 on three consecutive cycles, then out_valid=0.
- Backpressure: pending=0110, out_ready=0 for 5 cycles, req_in=0001 pulsed during the stall → out_code stays 01 throughout; on accept the next code is 00, then 10.
- Drop and re-request:
  - req_in=0010 while bit 1 is pending and not being served → dropped=1 for exactly one cycle, pending unchanged.
  - req_in=0010 on the cycle bit 1 is accepted → dropped=0, bit 1 remains pending and is issued again.
- Round-robin (macro defined): after last issued code 11, pulse req_in=1001 → codes 00 then 11. With req_in=1111 pulsed from reset → codes 00, 01, 10, 11.
